// File: rtl/muldiv_unit.sv
// Iterative MIPS-style multiply/divide unit with HI/LO registers.
// One radix-2 step per cycle on operand magnitudes (32 cycles), then one
// sign-fix cycle; MTHI/MTLO writes are accepted in any state.
module muldiv_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        StartE,
   input  logic [1:0]  OpE,
   input  logic [31:0] SrcAE,
   input  logic [31:0] SrcBE,
   input  logic        AbortE,
   input  logic        HiWriteW,
   input  logic        LoWriteW,
   input  logic [31:0] ResultW,
   output logic        MdBusy,
   output logic        MdDone,
   output logic [31:0] Hi,
   output logic [31:0] Lo
);

   localparam int unsigned W     = 32;
   localparam int unsigned CNT_W = 5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   count;
   logic [1:0]         op;
   logic [W-1:0]       src_a;     // raw dividend, returned as HI on divide-by-zero
   logic [W-1:0]       opb;       // magnitude of multiplicand / divisor
   logic               sign_a;
   logic               sign_b;
   logic               b_zero;
   logic [W-1:0]       acc_hi;    // product high half / partial remainder
   logic [W-1:0]       acc_lo;    // multiplier bits shifting out / quotient bits shifting in

   // Operand magnitudes computed from the launch inputs
   logic               start_signed;
   logic [W-1:0]       mag_a;
   logic [W-1:0]       mag_b;

   always_comb begin
      start_signed = ~OpE[0];
      mag_a        = (start_signed && SrcAE[W-1]) ? (~SrcAE + W'(1)) : SrcAE;
      mag_b        = (start_signed && SrcBE[W-1]) ? (~SrcBE + W'(1)) : SrcBE;
   end

   // One radix-2 iteration: shift-add multiply or restoring shift-subtract divide
   logic [W:0]   mul_sum;
   logic [W:0]   div_shift;
   logic         div_fits;
   logic [W-1:0] step_hi;
   logic [W-1:0] step_lo;

   always_comb begin
      step_hi   = acc_hi;
      step_lo   = acc_lo;
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : (W+1)'(0));
      div_shift = {acc_hi, acc_lo[W-1]};
      div_fits  = (div_shift >= {1'b0, opb});
      if (op[1]) begin
         if (div_fits) begin
            step_hi = W'(div_shift - {1'b0, opb});
            step_lo = {acc_lo[W-2:0], 1'b1};
         end else begin
            step_hi = W'(div_shift);
            step_lo = {acc_lo[W-2:0], 1'b0};
         end
      end else begin
         step_hi = mul_sum[W:1];
         step_lo = {mul_sum[0], acc_lo[W-1:1]};
      end
   end

   // Sign correction and HI/LO selection applied on the FIX cycle
   logic [2*W-1:0] prod;
   logic [2*W-1:0] prod_fix;
   logic [W-1:0]   quo_fix;
   logic [W-1:0]   rem_fix;
   logic [W-1:0]   res_hi;
   logic [W-1:0]   res_lo;

   always_comb begin
      prod     = {acc_hi, acc_lo};
      prod_fix = (sign_a ^ sign_b) ? (~prod + (2*W)'(1)) : prod;
      quo_fix  = (sign_a ^ sign_b) ? (~acc_lo + W'(1)) : acc_lo;
      rem_fix  = sign_a ? (~acc_hi + W'(1)) : acc_hi;
      res_hi   = prod_fix[2*W-1:W];
      res_lo   = prod_fix[W-1:0];
      if (op[1]) begin
         if (b_zero) begin
            res_hi = src_a;
            res_lo = '1;
         end else begin
            res_hi = rem_fix;
            res_lo = quo_fix;
         end
      end
   end

   // Control FSM, datapath registers and HI/LO with registered status outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= S_IDLE;
         count  <= '0;
         op     <= '0;
         src_a  <= '0;
         opb    <= '0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         b_zero <= 1'b0;
         acc_hi <= '0;
         acc_lo <= '0;
         MdBusy <= 1'b0;
         MdDone <= 1'b0;
         Hi     <= '0;
         Lo     <= '0;
      end else begin
         MdDone <= 1'b0;
         if (HiWriteW) Hi <= ResultW;
         if (LoWriteW) Lo <= ResultW;
         case (state)
            S_IDLE: begin
               if (StartE && !AbortE) begin
                  op     <= OpE;
                  src_a  <= SrcAE;
                  opb    <= mag_b;
                  sign_a <= start_signed & SrcAE[W-1];
                  sign_b <= start_signed & SrcBE[W-1];
                  b_zero <= (SrcBE == '0);
                  acc_hi <= '0;
                  acc_lo <= mag_a;
                  count  <= '0;
                  state  <= S_RUN;
                  MdBusy <= 1'b1;
               end
            end
            S_RUN: begin
               if (AbortE) begin
                  state  <= S_IDLE;
                  MdBusy <= 1'b0;
               end else begin
                  acc_hi <= step_hi;
                  acc_lo <= step_lo;
                  count  <= count + CNT_W'(1);
                  if (count == CNT_W'(W-1)) state <= S_FIX;
               end
            end
            S_FIX: begin
               state  <= S_IDLE;
               MdBusy <= 1'b0;
               if (!AbortE) begin
                  Hi     <= res_hi;
                  Lo     <= res_lo;
                  MdDone <= 1'b1;
               end
            end
            default: begin
               state  <= S_IDLE;
               MdBusy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, hand-written
// multi-cycle sequences, and random operations against an arithmetic model.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        StartE;
   logic [1:0]  OpE;
   logic [31:0] SrcAE;
   logic [31:0] SrcBE;
   logic        AbortE;
   logic        HiWriteW;
   logic        LoWriteW;
   logic [31:0] ResultW;
   logic        MdBusy;
   logic        MdDone;
   logic [31:0] Hi;
   logic [31:0] Lo;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   int vectors     = 0;
   int miscompares = 0;

   muldiv_unit dut (
      .clk      (clk),
      .reset    (reset),
      .StartE   (StartE),
      .OpE      (OpE),
      .SrcAE    (SrcAE),
      .SrcBE    (SrcBE),
      .AbortE   (AbortE),
      .HiWriteW (HiWriteW),
      .LoWriteW (LoWriteW),
      .ResultW  (ResultW),
      .MdBusy   (MdBusy),
      .MdDone   (MdDone),
      .Hi       (Hi),
      .Lo       (Lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Launch an op; returns in cycle 1 of the operation
   task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      OpE    = op;
      SrcAE  = a;
      SrcBE  = b;
      StartE = 1'b1;
      step();
      StartE = 1'b0;
   endtask

   // Full op with latency, pulse and result checks; returns in cycle 35
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input string name);
      int bad;
      bad = 0;
      start_op(op, a, b);
      for (int c = 1; c <= 33; c++) begin
         if (MdBusy !== 1'b1 || MdDone !== 1'b0) bad++;
         step();
      end
      check({name, "_busy_window"}, 32'(bad), 32'd0);
      check({name, "_done_pulse"}, {30'd0, MdDone, MdBusy}, 32'h2);
      check({name, "_hi"}, Hi, ehi);
      check({name, "_lo"}, Lo, elo);
      step();
      check({name, "_done_drop"}, 32'(MdDone), 32'd0);
   endtask

   // Architectural reference: plain 64-bit arithmetic on the specified rules
   function automatic void ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo);
      longint          sa, sb, sp, q, r;
      longint unsigned up;
      sa = longint'(int'(a));
      sb = longint'(int'(b));
      hi = '0;
      lo = '0;
      case (op)
         OP_MULT: begin
            sp = sa * sb;
            hi = sp[63:32];
            lo = sp[31:0];
         end
         OP_MULTU: begin
            up = 64'(a) * 64'(b);
            hi = up[63:32];
            lo = up[31:0];
         end
         OP_DIV: begin
            if (b == 32'd0) begin
               hi = a;
               lo = 32'hFFFF_FFFF;
            end else begin
               q  = sa / sb;
               r  = sa % sb;
               hi = r[31:0];
               lo = q[31:0];
            end
         end
         default: begin
            if (b == 32'd0) begin
               hi = a;
               lo = 32'hFFFF_FFFF;
            end else begin
               hi = a % b;
               lo = a / b;
            end
         end
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vt [10];
      logic [1:0]  rop;
      logic [31:0] ra, rb, rhi, rlo;
      int          cnt;

      vt[0] = '{OP_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA};
      vt[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      vt[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vt[3] = '{OP_DIVU,  32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF};
      vt[4] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
      vt[5] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
      vt[6] = '{OP_DIV,   32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF};
      vt[7] = '{OP_DIVU,  32'hFFFF_FFFF, 32'd10,        32'h0000_0005, 32'h1999_9999};
      vt[8] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
      vt[9] = '{OP_MULTU, 32'd2,         32'd3,         32'h0000_0000, 32'h0000_0006};

      reset    = 1'b1;
      StartE   = 1'b0;
      OpE      = '0;
      SrcAE    = '0;
      SrcBE    = '0;
      AbortE   = 1'b0;
      HiWriteW = 1'b0;
      LoWriteW = 1'b0;
      ResultW  = '0;

      // Reset state
      #1;
      check("reset_hi",   Hi, 32'd0);
      check("reset_lo",   Lo, 32'd0);
      check("reset_flags", {30'd0, MdBusy, MdDone}, 32'd0);
      steps(2);
      #3 reset = 1'b0;

      // Directed table; the first op launches on the first edge after reset
      for (int i = 0; i < 10; i++)
         run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo, $sformatf("table%0d", i));

      // StartE while busy is ignored
      start_op(OP_MULT, 32'hFFFF_FFFE, 32'd3);
      steps(4);
      OpE = OP_DIVU; SrcAE = 32'd100; SrcBE = 32'd7; StartE = 1'b1;
      step();
      StartE = 1'b0;
      steps(28);
      check("ignored_start_done", 32'(MdDone), 32'd1);
      check("ignored_start_hi", Hi, 32'hFFFF_FFFF);
      check("ignored_start_lo", Lo, 32'hFFFF_FFFA);
      step();
      check("ignored_start_no_relaunch", 32'(MdBusy), 32'd0);

      // Abort during RUN at cycle 10
      start_op(OP_DIV, 32'd1000, 32'd7);
      steps(9);
      AbortE = 1'b1;
      step();
      AbortE = 1'b0;
      check("abort_run_busy", 32'(MdBusy), 32'd0);
      cnt = 0;
      for (int c = 0; c < 30; c++) begin
         if (MdDone !== 1'b0 || MdBusy !== 1'b0) cnt++;
         step();
      end
      check("abort_run_quiet", 32'(cnt), 32'd0);
      check("abort_run_hi", Hi, 32'hFFFF_FFFF);
      check("abort_run_lo", Lo, 32'hFFFF_FFFA);

      // Abort during FIX (cycle 33)
      start_op(OP_DIVU, 32'd100, 32'd7);
      steps(32);
      AbortE = 1'b1;
      step();
      AbortE = 1'b0;
      check("abort_fix_flags", {30'd0, MdBusy, MdDone}, 32'd0);
      check("abort_fix_hi", Hi, 32'hFFFF_FFFF);
      check("abort_fix_lo", Lo, 32'hFFFF_FFFA);

      // StartE with AbortE in IDLE: not started
      StartE = 1'b1; AbortE = 1'b1; OpE = OP_MULTU; SrcAE = 32'd9; SrcBE = 32'd9;
      step();
      StartE = 1'b0; AbortE = 1'b0;
      check("abort_idle_busy", 32'(MdBusy), 32'd0);
      cnt = 0;
      for (int c = 0; c < 36; c++) begin
         if (MdDone !== 1'b0) cnt++;
         step();
      end
      check("abort_idle_no_done", 32'(cnt), 32'd0);

      // MTLO / MTHI in IDLE
      LoWriteW = 1'b1; ResultW = 32'h1234_5678;
      step();
      LoWriteW = 1'b0;
      check("mtlo_idle", Lo, 32'h1234_5678);
      HiWriteW = 1'b1; ResultW = 32'hCAFE_F00D;
      step();
      HiWriteW = 1'b0;
      check("mthi_idle", Hi, 32'hCAFE_F00D);

      // MTLO during RUN, then MTHI/MTLO colliding with the result write
      start_op(OP_MULTU, 32'd2, 32'd3);
      steps(2);
      LoWriteW = 1'b1; ResultW = 32'hAAAA_5555;
      step();
      LoWriteW = 1'b0;
      check("mtlo_run", Lo, 32'hAAAA_5555);
      steps(29);
      LoWriteW = 1'b1; HiWriteW = 1'b1; ResultW = 32'h1234_5678;
      step();
      LoWriteW = 1'b0; HiWriteW = 1'b0;
      check("mt_collide_done", 32'(MdDone), 32'd1);
      check("mt_collide_lo", Lo, 32'd6);
      check("mt_collide_hi", Hi, 32'd0);

      // Back-to-back launch in cycle 34
      start_op(OP_MULTU, 32'd5, 32'd7);
      steps(33);
      check("b2b_first_lo", Lo, 32'd35);
      OpE = OP_DIVU; SrcAE = 32'd35; SrcBE = 32'd5; StartE = 1'b1;
      step();
      StartE = 1'b0;
      check("b2b_accepted", 32'(MdBusy), 32'd1);
      steps(33);
      check("b2b_second_done", 32'(MdDone), 32'd1);
      check("b2b_second_lo", Lo, 32'd7);
      check("b2b_second_hi", Hi, 32'd0);
      step();

      // Asynchronous reset in cycle 20 of a DIV
      run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "pre_reset");
      start_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
      steps(19);
      #2 reset = 1'b1;
      #1;
      check("async_reset_hi", Hi, 32'd0);
      check("async_reset_lo", Lo, 32'd0);
      check("async_reset_flags", {30'd0, MdBusy, MdDone}, 32'd0);
      #2 reset = 1'b0;
      run_op(OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, "post_reset");

      // Random operations against the reference model
      for (int i = 0; i < 40; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         case ($urandom_range(0, 7))
            0:       rb = 32'd0;
            1:       rb = 32'($urandom_range(1, 15));
            2:       rb = 32'hFFFF_FFFF;
            default: rb = $urandom;
         endcase
         if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
         ref_model(rop, ra, rb, rhi, rlo);
         run_op(rop, ra, rb, rhi, rlo, $sformatf("rand%0d_op%0d", i, rop));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
